mem_arb_2to1_valrdy: RTL and testbench

- Two-client arbiter in front of one masked_mem_wrap_valrdy instance, so that two engines can share one DRAM/BRAM memory port.
- Commands pass through with zero latency. Grant is round-robin at command granularity.
- A write burst locks the grant until its last beat.
- Read bursts are logged in an order FIFO so returned beats are steered to the client that issued them.

---
 rtl/mem_arb_2to1_valrdy.sv | 219 +++++++++++++++++++++
 tb/tb_mem_arb_2to1_valrdy.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_2to1_valrdy.sv
// rtl/mem_arb_2to1_valrdy.sv - two-client round-robin arbiter in front of one val/rdy memory wrapper
// Write bursts lock the grant; a read order FIFO steers returned beats to the issuing client.

module mem_arb_rd_order_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

module mem_arb_2to1_valrdy #(
  parameter int MEM_ADDR_W    = 10,
  parameter int MEM_DATA_W    = 512,
  parameter int MEM_WR_MASK_W = MEM_DATA_W/8,
  parameter int RD_Q_DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 ctrl_arb_write_en,
  input  logic [1:0]                 ctrl_arb_read_en,
  input  logic [2*MEM_ADDR_W-1:0]    ctrl_arb_addr,
  input  logic [2*MEM_DATA_W-1:0]    ctrl_arb_wr_data,
  input  logic [2*MEM_WR_MASK_W-1:0] ctrl_arb_byte_en,
  input  logic [2*7-1:0]             ctrl_arb_burst_cnt,
  output logic [1:0]                 arb_ctrl_rdy,
  output logic [1:0]                 arb_ctrl_rd_data_val,
  output logic [MEM_DATA_W-1:0]      arb_ctrl_rd_data,
  input  logic [1:0]                 ctrl_arb_rd_data_rdy,
  output logic                       arb_wrap_write_en,
  output logic                       arb_wrap_read_en,
  output logic [MEM_ADDR_W-1:0]      arb_wrap_addr,
  output logic [MEM_DATA_W-1:0]      arb_wrap_wr_data,
  output logic [MEM_WR_MASK_W-1:0]   arb_wrap_byte_en,
  output logic [6:0]                 arb_wrap_burst_cnt,
  input  logic                       wrap_arb_rdy,
  input  logic                       wrap_arb_rd_data_val,
  input  logic [MEM_DATA_W-1:0]      wrap_arb_rd_data,
  output logic                       arb_wrap_rd_data_rdy
);
  typedef enum logic {ST_IDLE, ST_WR_BURST} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       owner_q, owner_d;
  logic       hold_q, hold_d;
  logic       hold_gnt_q, hold_gnt_d;
  logic [6:0] beats_left_q, beats_left_d;
  logic [6:0] rd_beat_q, rd_beat_d;

  logic [1:0] req;
  logic       gnt, gnt_val, block_ok, accept;
  logic [6:0] gnt_bc, gnt_bc_eff;
  logic       q_push, q_pop, q_empty, q_full, rd_hs, h;
  logic [7:0] q_head;

  assign req = ctrl_arb_write_en | ctrl_arb_read_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      hold_q       <= 1'b0;
      hold_gnt_q   <= 1'b0;
      beats_left_q <= '0;
      rd_beat_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      hold_q       <= hold_d;
      hold_gnt_q   <= hold_gnt_d;
      beats_left_q <= beats_left_d;
      rd_beat_q    <= rd_beat_d;
    end
  end

  // A granted but unaccepted command (wrapper stall or full FIFO) pins the grant.
  always_comb begin
    gnt     = 1'b0;
    gnt_val = 1'b0;
    if (state_q == ST_WR_BURST) begin
      gnt     = owner_q;
      gnt_val = 1'b1;
    end else if (hold_q && req[hold_gnt_q]) begin
      gnt     = hold_gnt_q;
      gnt_val = 1'b1;
    end else if (&req) begin
      gnt     = ~last_grant_q;
      gnt_val = 1'b1;
    end else if (req[0]) begin
      gnt_val = 1'b1;
    end else if (req[1]) begin
      gnt     = 1'b1;
      gnt_val = 1'b1;
    end
    if (rst) gnt_val = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    hold_d       = 1'b0;
    hold_gnt_d   = gnt;
    beats_left_d = beats_left_q;
    rd_beat_d    = rd_beat_q;
    case (state_q)
      ST_IDLE: begin
        hold_d = gnt_val & ~accept;
        if (accept) begin
          if (arb_wrap_write_en && gnt_bc_eff > 7'd1) begin
            state_d      = ST_WR_BURST;
            beats_left_d = gnt_bc_eff - 7'd1;
            owner_d      = gnt;
          end else begin
            last_grant_d = gnt;
          end
        end
      end
      ST_WR_BURST: begin
        if (accept) begin
          beats_left_d = beats_left_q - 7'd1;
          if (beats_left_q == 7'd1) begin
            state_d      = ST_IDLE;
            last_grant_d = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (q_pop)      rd_beat_d = '0;
    else if (rd_hs) rd_beat_d = rd_beat_q + 7'd1;
  end

  always_comb begin
    gnt_bc            = gnt ? ctrl_arb_burst_cnt[13:7] : ctrl_arb_burst_cnt[6:0];
    gnt_bc_eff        = (gnt_bc == 7'd0) ? 7'd1 : gnt_bc;
    block_ok          = ~((state_q == ST_IDLE) && ctrl_arb_read_en[gnt] && q_full);
    arb_wrap_write_en = gnt_val & ctrl_arb_write_en[gnt];
    arb_wrap_read_en  = gnt_val & ctrl_arb_read_en[gnt] & (state_q == ST_IDLE) & block_ok;
    accept            = (arb_wrap_write_en | arb_wrap_read_en) & wrap_arb_rdy;
    arb_ctrl_rdy[0]   = wrap_arb_rdy & gnt_val & ~gnt & block_ok;
    arb_ctrl_rdy[1]   = wrap_arb_rdy & gnt_val & gnt & block_ok;
    arb_wrap_addr      = '0;
    arb_wrap_wr_data   = '0;
    arb_wrap_byte_en   = '0;
    arb_wrap_burst_cnt = '0;
    if (gnt_val) begin
      arb_wrap_addr      = gnt ? ctrl_arb_addr[2*MEM_ADDR_W-1:MEM_ADDR_W] : ctrl_arb_addr[MEM_ADDR_W-1:0];
      arb_wrap_wr_data   = gnt ? ctrl_arb_wr_data[2*MEM_DATA_W-1:MEM_DATA_W] : ctrl_arb_wr_data[MEM_DATA_W-1:0];
      arb_wrap_byte_en   = gnt ? ctrl_arb_byte_en[2*MEM_WR_MASK_W-1:MEM_WR_MASK_W]
                               : ctrl_arb_byte_en[MEM_WR_MASK_W-1:0];
      arb_wrap_burst_cnt = gnt_bc;
    end
  end

  // With nothing logged, beats are accepted and dropped so stale data drains.
  assign h      = q_head[7];
  assign q_push = accept & arb_wrap_read_en;
  assign rd_hs  = ~rst & ~q_empty & wrap_arb_rd_data_val & ctrl_arb_rd_data_rdy[h];
  assign q_pop  = rd_hs & ((rd_beat_q + 7'd1) == q_head[6:0]);

  always_comb begin
    arb_ctrl_rd_data_val = 2'b00;
    if (!rst && !q_empty) arb_ctrl_rd_data_val[h] = wrap_arb_rd_data_val;
    arb_wrap_rd_data_rdy = rst | q_empty | ctrl_arb_rd_data_rdy[h];
    arb_ctrl_rd_data     = rst ? '0 : wrap_arb_rd_data;
  end

  mem_arb_rd_order_fifo #(.W(8), .DEPTH(RD_Q_DEPTH)) u_rd_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({gnt, gnt_bc_eff}),
    .pop       (q_pop),
    .head_data (q_head),
    .empty     (q_empty),
    .full      (q_full)
  );
endmodule

// File: tb/tb_mem_arb_2to1_valrdy.sv
// tb/tb_mem_arb_2to1_valrdy.sv - scoreboard bench for mem_arb_2to1_valrdy
module tb_mem_arb_2to1_valrdy;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = DW/8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      we, re, rd_rdy, rdy, rd_val;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [2*MW-1:0] be;
  logic [13:0]     bc;
  logic [DW-1:0]   rd_data, wrap_rd_data, wrap_wr_data;
  logic            wrap_we, wrap_re, wrap_rdy, wrap_rd_val, wrap_rd_rdy;
  logic [AW-1:0]   wrap_addr;
  logic [MW-1:0]   wrap_be;
  logic [6:0]      wrap_bc;

  int total = 0;
  int bad   = 0;
  int n0, n1;
  logic [31:0] exp_cmd_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] mon_e;

  always #5 clk = ~clk;

  mem_arb_2to1_valrdy #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_WR_MASK_W(MW), .RD_Q_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .ctrl_arb_write_en(we), .ctrl_arb_read_en(re), .ctrl_arb_addr(addr),
    .ctrl_arb_wr_data(wdata), .ctrl_arb_byte_en(be), .ctrl_arb_burst_cnt(bc),
    .arb_ctrl_rdy(rdy), .arb_ctrl_rd_data_val(rd_val), .arb_ctrl_rd_data(rd_data),
    .ctrl_arb_rd_data_rdy(rd_rdy),
    .arb_wrap_write_en(wrap_we), .arb_wrap_read_en(wrap_re), .arb_wrap_addr(wrap_addr),
    .arb_wrap_wr_data(wrap_wr_data), .arb_wrap_byte_en(wrap_be), .arb_wrap_burst_cnt(wrap_bc),
    .wrap_arb_rdy(wrap_rdy), .wrap_arb_rd_data_val(wrap_rd_val), .wrap_arb_rd_data(wrap_rd_data),
    .arb_wrap_rd_data_rdy(wrap_rd_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecmd(input logic w, input logic r, input logic [AW-1:0] a, input logic [31:0] d);
    return {4'b0, w, r, a, d[15:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cli(input int i, input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [6:0] b);
    we[i] = w;
    re[i] = r;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    be[i*MW +: MW] = '1;
    bc[i*7 +: 7] = b;
  endtask

  task automatic idle_all;
    set_cli(0, 1'b0, 1'b0, '0, '0, '0);
    set_cli(1, 1'b0, 1'b0, '0, '0, '0);
    rd_rdy = 2'b11;
    wrap_rdy = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_all();
    wrap_rd_val = 1'b0;
    wrap_rd_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_left(input string tag);
    chk({tag, "_cmd_left"}, exp_cmd_q.size(), 0);
    chk({tag, "_rd_left"}, exp_rd_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && wrap_rdy && (wrap_we || wrap_re)) begin
      if (exp_cmd_q.size() > 0) mon_e = exp_cmd_q.pop_front();
      else mon_e = 32'hFFFF_FFFF;
      chk("cmd", {4'b0, wrap_we, wrap_re, wrap_addr, wrap_wr_data[15:0]}, mon_e);
      if (wrap_addr[9]) n1++;
      else n0++;
    end
    if (!rst && wrap_rd_val && wrap_rd_rdy && (rd_val != 2'b00)) begin
      if (exp_rd_q.size() > 0) mon_e = exp_rd_q.pop_front();
      else mon_e = 32'hFFFF_FFFF;
      chk("rd_beat", {rd_val, rd_data[29:0]}, mon_e);
    end
  end

  initial begin
    rst = 1'b1;
    idle_all();
    wrap_rd_val = 1'b1;
    wrap_rd_data = 32'h55;
    set_cli(0, 1'b1, 1'b0, 10'h101, 32'hA9, 7'd1);
    @(negedge clk);
    chk("rst_rdy", rdy, 2'b00);
    chk("rst_en", {wrap_we, wrap_re}, 2'b00);
    chk("rst_addr", wrap_addr, 0);
    chk("rst_rd_val", rd_val, 2'b00);
    chk("rst_rd_rdy", wrap_rd_rdy, 1);
    tick();
    do_reset();

    // alternation, client1 uses burst_cnt 0 which counts as one beat
    n0 = 0;
    n1 = 0;
    set_cli(0, 1'b1, 1'b0, 10'h100, 32'hA0, 7'd1);
    set_cli(1, 1'b1, 1'b0, 10'h200, 32'hB0, 7'd0);
    for (int k = 0; k < 20; k++)
      exp_cmd_q.push_back((k % 2) ? ecmd(1, 0, 10'h200, 32'hB0) : ecmd(1, 0, 10'h100, 32'hA0));
    repeat (20) tick();
    idle_all();
    chk("alt_n0", n0, 10);
    chk("alt_n1", n1, 10);
    chk_left("alt");

    // write burst lock
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_cli(1, 1'b1, 1'b0, 10'h210, 32'hB10 + k, 7'd4);
      if (k >= 1) set_cli(0, 1'b0, 1'b1, 10'h110, 32'hA1, 7'd1);
      exp_cmd_q.push_back(ecmd(1, 0, 10'h210, 32'hB10 + k));
      @(negedge clk);
      chk("lock_rdy0", rdy[0], 0);
      chk("lock_rdy1", rdy[1], 1);
      tick();
    end
    set_cli(1, 1'b0, 1'b0, '0, '0, '0);
    exp_cmd_q.push_back(ecmd(0, 1, 10'h110, 32'hA1));
    @(negedge clk);
    chk("post_lock_rdy0", rdy[0], 1);
    tick();
    idle_all();
    chk_left("lock");

    // stall hold
    do_reset();
    wrap_rdy = 1'b0;
    set_cli(0, 1'b0, 1'b1, 10'h130, 32'hA3, 7'd1);
    set_cli(1, 1'b1, 1'b0, 10'h230, 32'hB3, 7'd1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_addr", wrap_addr, 10'h130);
      chk("stall_rdy", rdy, 2'b00);
      tick();
    end
    wrap_rdy = 1'b1;
    exp_cmd_q.push_back(ecmd(0, 1, 10'h130, 32'hA3));
    exp_cmd_q.push_back(ecmd(1, 0, 10'h230, 32'hB3));
    exp_cmd_q.push_back(ecmd(0, 1, 10'h130, 32'hA3));
    tick();
    tick();
    set_cli(1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    idle_all();
    chk_left("stall");

    // read steering
    do_reset();
    set_cli(0, 1'b0, 1'b1, 10'h140, 32'hA4, 7'd2);
    exp_cmd_q.push_back(ecmd(0, 1, 10'h140, 32'hA4));
    tick();
    set_cli(0, 1'b0, 1'b0, '0, '0, '0);
    set_cli(1, 1'b0, 1'b1, 10'h240, 32'hB4, 7'd0);
    exp_cmd_q.push_back(ecmd(0, 1, 10'h240, 32'hB4));
    tick();
    idle_all();
    wrap_rd_val = 1'b1;
    wrap_rd_data = 32'hDA;
    rd_rdy = 2'b10;
    repeat (2) begin
      @(negedge clk);
      chk("steer_stall_rdy", wrap_rd_rdy, 0);
      chk("steer_stall_val", rd_val, 2'b01);
      tick();
    end
    rd_rdy = 2'b11;
    exp_rd_q.push_back({2'b01, 30'hDA});
    tick();
    wrap_rd_data = 32'hDB;
    exp_rd_q.push_back({2'b01, 30'hDB});
    tick();
    wrap_rd_data = 32'hDC;
    exp_rd_q.push_back({2'b10, 30'hDC});
    tick();
    wrap_rd_data = 32'hDD;
    @(negedge clk);
    chk("drop_val", rd_val, 2'b00);
    chk("drop_rdy", wrap_rd_rdy, 1);
    tick();
    wrap_rd_val = 1'b0;
    chk_left("steer");

    // read order FIFO full
    do_reset();
    set_cli(0, 1'b0, 1'b1, 10'h150, 32'hA5, 7'd1);
    for (int k = 0; k < 8; k++) exp_cmd_q.push_back(ecmd(0, 1, 10'h150, 32'hA5));
    repeat (8) tick();
    @(negedge clk);
    chk("full_rdy0", rdy[0], 0);
    chk("full_re", wrap_re, 0);
    tick();
    set_cli(1, 1'b1, 1'b0, 10'h250, 32'hB5, 7'd1);
    @(negedge clk);
    chk("full_rdy", rdy, 2'b00);
    chk("full_we", wrap_we, 0);
    tick();
    wrap_rd_val = 1'b1;
    wrap_rd_data = 32'hF0;
    exp_rd_q.push_back({2'b01, 30'hF0});
    @(negedge clk);
    chk("pop_cycle_rdy0", rdy[0], 0);
    tick();
    wrap_rd_val = 1'b0;
    exp_cmd_q.push_back(ecmd(0, 1, 10'h150, 32'hA5));
    @(negedge clk);
    chk("after_pop_rdy0", rdy[0], 1);
    tick();
    set_cli(0, 1'b0, 1'b0, '0, '0, '0);
    exp_cmd_q.push_back(ecmd(1, 0, 10'h250, 32'hB5));
    tick();
    idle_all();
    chk_left("full");

    // reset mid-burst
    do_reset();
    set_cli(0, 1'b1, 1'b0, 10'h160, 32'hA6, 7'd4);
    exp_cmd_q.push_back(ecmd(1, 0, 10'h160, 32'hA6));
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", rdy, 2'b00);
    chk("mid_rst_we", wrap_we, 0);
    tick();
    rst = 1'b0;
    set_cli(0, 1'b1, 1'b0, 10'h160, 32'hA7, 7'd1);
    set_cli(1, 1'b1, 1'b0, 10'h260, 32'hB7, 7'd1);
    exp_cmd_q.push_back(ecmd(1, 0, 10'h160, 32'hA7));
    exp_cmd_q.push_back(ecmd(1, 0, 10'h260, 32'hB7));
    @(negedge clk);
    chk("post_rst_tie", rdy, 2'b01);
    tick();
    tick();
    idle_all();
    chk_left("mid_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
